// File: rtl/alu_result_stage.sv
// Registered result stage behind the 4-bit adder: derives C/V/N/Z, buffers result+flags
// in a small valid/ready FIFO, and counts accepted overflow results (saturating).
module alu_result_stage #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_co,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] ov_count,
  input  logic             ov_clear
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENT_W = WIDTH + 4;
  localparam logic [PTR_W:0]   CountFull = DEPTH[PTR_W:0];
  localparam logic [PTR_W-1:0] LastPtr   = PTR_W'(DEPTH - 1);

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic [CNT_W-1:0] r_ov_count;

  logic             w_push;
  logic             w_pop;
  logic             w_b_eff;
  logic             w_c;
  logic             w_v;
  logic             w_n;
  logic             w_z;
  logic [ENT_W-1:0] w_entry;
  logic [ENT_W-1:0] w_head;
  logic             w_ov_sat;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Subtract feeds ~b into the adder, so the effective operand sign is b_msb ^ sub.
  assign w_b_eff = in_b_msb ^ in_sub;
  assign w_c     = in_co;
  assign w_n     = in_result[WIDTH-1];
  assign w_v     = (in_a_msb ^ w_n) & (w_b_eff ^ w_n);
  assign w_z     = (in_result == '0);
  assign w_entry = {in_result, w_c, w_v, w_n, w_z};

  // Handshake status comes only from registered occupancy.
  assign in_ready  = (r_count != CountFull);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_ov_sat  = (r_ov_count == '1);

  assign w_head     = r_mem[r_rd_ptr];
  assign out_result = w_head[ENT_W-1:4];
  assign out_flags  = w_head[3:0];
  assign ov_count   = r_ov_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_ov_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (ov_clear) begin
        r_ov_count <= '0;
      end else if (w_push && w_v && !w_ov_sat) begin
        r_ov_count <= r_ov_count + 1'b1;
      end
    end
  end

endmodule
